// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter/sequencer sharing one SDRAM controller host port between a display reader and a host writer.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise reads have fixed priority over writes.
`timescale 1ns/1ps
module sdram_port_arbiter #(
  parameter int HADDR_WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_req,
  input  logic [HADDR_WIDTH-1:0] rd_addr,
  output logic [15:0]            rd_data,
  output logic                   rd_valid,
  output logic                   rd_ack,
  input  logic                   wr_req,
  input  logic [HADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]            wr_data,
  output logic                   wr_ack,
  output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
  output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
  output logic [15:0]            ctl_wr_data,
  output logic                   ctl_rd_enable,
  output logic                   ctl_wr_enable,
  output logic                   ctl_rd_ready,
  input  logic [15:0]            ctl_rd_data,
  input  logic                   ctl_wr_addr_inc,
  input  logic                   ctl_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DRAIN, ROTATE} state_t;

  state_t     state;
  logic       owner_wr;
  logic [1:0] drain_cnt;
  logic       grant_rd;
  logic       grant_wr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_wr;

  // Contention goes to whichever client was not served last.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_req && wr_req) begin
      grant_rd = last_wr;
      grant_wr = !last_wr;
    end else begin
      grant_rd = rd_req;
      grant_wr = wr_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_wr <= 1'b1;
    else if (state == IDLE && !ctl_busy && (grant_rd || grant_wr))
      last_wr <= grant_wr;
  end
`else
  always_comb begin
    grant_rd = rd_req;
    grant_wr = wr_req && !rd_req;
  end
`endif

  assign wr_ack = ctl_wr_addr_inc && owner_wr && (state == ISSUE || state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner_wr      <= 1'b0;
      drain_cnt     <= 2'd0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      rd_ack        <= 1'b0;
      ctl_rd_addr   <= '0;
      ctl_wr_addr   <= '0;
      ctl_wr_data   <= '0;
      ctl_rd_enable <= 1'b0;
      ctl_wr_enable <= 1'b0;
      ctl_rd_ready  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (!ctl_busy && (grant_rd || grant_wr)) begin
            owner_wr <= grant_wr;
            if (grant_wr) begin
              ctl_wr_addr   <= wr_addr;
              ctl_wr_data   <= wr_data;
              ctl_wr_enable <= 1'b1;
            end else begin
              ctl_rd_addr   <= rd_addr;
              ctl_rd_enable <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        // The enable stays up across a refresh so the controller picks it up once idle again.
        ISSUE: begin
          if (ctl_busy) begin
            ctl_rd_enable <= 1'b0;
            ctl_wr_enable <= 1'b0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (!ctl_busy) begin
            if (owner_wr) begin
              state <= IDLE;
            end else begin
              drain_cnt <= 2'd0;
              state     <= DRAIN;
            end
          end
        end
        // Each posedge captures the current head word; the strobe shifts at the following negedge.
        DRAIN: begin
          rd_data      <= ctl_rd_data;
          rd_valid     <= 1'b1;
          ctl_rd_ready <= 1'b1;
          drain_cnt    <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd3) begin
            rd_ack <= 1'b1;
            state  <= ROTATE;
          end
        end
        ROTATE: begin
          ctl_rd_ready <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a behavioural SDRAM controller host-port model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0]   rd_data;
  logic          rd_valid, rd_ack;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          wr_ack;
  logic [AW-1:0] ctl_rd_addr, ctl_wr_addr;
  logic [15:0]   ctl_wr_data;
  logic          ctl_rd_enable, ctl_wr_enable, ctl_rd_ready;
  logic [15:0]   ctl_rd_data;
  logic          ctl_wr_addr_inc = 1'b0;
  logic          ctl_busy = 1'b0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.HADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ctl_rd_addr(ctl_rd_addr), .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data),
    .ctl_rd_enable(ctl_rd_enable), .ctl_wr_enable(ctl_wr_enable), .ctl_rd_ready(ctl_rd_ready),
    .ctl_rd_data(ctl_rd_data), .ctl_wr_addr_inc(ctl_wr_addr_inc), .ctl_busy(ctl_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fw(input logic [AW-1:0] a, input int i);
    return a[15:0] ^ (16'hA5C3 + 16'(i) * 16'h1111);
  endfunction

  // Controller model: busy lags the internal state one cycle, refresh swallows commands with busy low.
  typedef enum int {M_IDLE, M_RD, M_WR, M_REF} mst_t;
  mst_t          mst = M_IDLE;
  int            mcnt = 0;
  int            init_len = 20;
  int            init_cnt = 0;
  int            n_reads = 0;
  int            n_writes = 0;
  logic          ref_go = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_waddr = '0;
  logic [15:0]   m_wdata = '0;
  logic [15:0]   mem_w [4];
  logic [1:0]    rot = 2'd0;

  assign ctl_rd_data = mem_w[rot];

  always @(posedge clk) begin
    ctl_wr_addr_inc <= 1'b0;
    if (rst) begin
      mst      <= M_IDLE;
      mcnt     <= 0;
      init_cnt <= init_len;
      ctl_busy <= (init_len != 0);
    end else begin
      if (init_cnt != 0) init_cnt <= init_cnt - 1;
      case (mst)
        M_IDLE: begin
          if (ref_go) begin
            mst <= M_REF; mcnt <= 12;
          end else if (ctl_rd_enable) begin
            mst <= M_RD; mcnt <= 5; m_addr <= ctl_rd_addr; n_reads <= n_reads + 1;
          end else if (ctl_wr_enable) begin
            mst <= M_WR; mcnt <= 3; m_waddr <= ctl_wr_addr; m_wdata <= ctl_wr_data;
            n_writes <= n_writes + 1; ctl_wr_addr_inc <= 1'b1;
          end
        end
        default: begin
          if (mcnt == 0) begin
            if (mst == M_RD)
              for (int i = 0; i < 4; i++) mem_w[i] <= fw(m_addr, i);
            mst <= M_IDLE;
          end else begin
            mcnt <= mcnt - 1;
          end
        end
      endcase
      ctl_busy <= (init_cnt != 0) || (mst == M_RD) || (mst == M_WR);
    end
  end

  always @(negedge clk) begin
    if (rst) rot <= 2'd0;
    else if (ctl_rd_ready) rot <= rot + 2'd1;
  end

  // Monitor and scoreboard
  logic [1:0]  exp_grant [$];
  logic [15:0] sb [$];
  logic [1:0]  en_now;
  logic [1:0]  prev_en = 2'b00;
  logic        prev_busy = 1'b0;
  int en_len = 0, last_en_len = 0, vld_run = 0, rdy_run = 0;
  int rd_acks = 0, wr_acks = 0, rd_acks_at_wgrant = 0;

  always @(negedge clk) begin
    en_now = {ctl_wr_enable, ctl_rd_enable};
    if (rst) begin
      vld_run = 0; rdy_run = 0; en_len = 0;
    end else begin
      if (en_now != 2'b00 && prev_en == 2'b00) begin
        chk("grant_busy", 32'(prev_busy), 32'd0);
        if (exp_grant.size() == 0) chk("grant_unexp", 32'(en_now), 32'd0);
        else chk("grant_owner", 32'(en_now), 32'(exp_grant.pop_front()));
        if (ctl_rd_enable) begin
          chk("grant_rd_addr", 32'(ctl_rd_addr), 32'(rd_addr));
          for (int i = 0; i < 4; i++) sb.push_back(fw(rd_addr, i));
        end else begin
          chk("grant_wr_addr", 32'(ctl_wr_addr), 32'(wr_addr));
          chk("grant_wr_data", 32'(ctl_wr_data), 32'(wr_data));
          rd_acks_at_wgrant = rd_acks;
        end
      end
      if (en_now == 2'b00 && prev_en != 2'b00) begin
        chk("en_drop_busy", 32'(prev_busy), 32'd1);
        last_en_len = en_len;
        en_len = 0;
      end
      if (en_now != 2'b00) en_len++;
      if (rd_valid) begin
        vld_run++;
        if (sb.size() == 0) chk("rd_unexp", 32'd1, 32'd0);
        else chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
      end else begin
        vld_run = 0;
      end
      if (rd_ack) begin
        rd_acks++;
        chk("rd_ack_4th", 32'(vld_run), 32'd4);
      end
      if (ctl_rd_ready) begin
        rdy_run++;
      end else if (rdy_run != 0) begin
        chk("rdy_len", 32'(rdy_run), 32'd4);
        chk("rot_restore", 32'(rot), 32'd0);
        rdy_run = 0;
      end
      if (wr_ack) begin
        wr_acks++;
        chk("wr_ack_inc", 32'(ctl_wr_addr_inc), 32'd1);
      end
    end
    prev_en = en_now;
    prev_busy = ctl_busy;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input string tag, input int rt, input int wt);
    int n = 0;
    while ((rd_acks < rt || wr_acks < wt) && n < 400) begin
      @(negedge clk); #1; n++;
    end
    chk(tag, 32'(rd_acks >= rt && wr_acks >= wt), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"},   32'({ctl_rd_enable, ctl_wr_enable, ctl_rd_ready}), 32'd0);
    chk({tag, "_flags"}, 32'({rd_valid, rd_ack, wr_ack}), 32'd0);
    chk({tag, "_rdata"}, 32'(rd_data), 32'd0);
    chk({tag, "_addr"},  32'(ctl_rd_addr | ctl_wr_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(ctl_wr_data), 32'd0);
  endtask

  initial begin
    int br, bw, bn, n, en_cycles;
    // Reset with the controller held in init
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst");
    #1 rst = 1'b0;
    wr_addr = 22'h000100; wr_data = 16'h1234;
    exp_grant.push_back(2'b10);
    wr_req = 1'b1;
    en_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (ctl_rd_enable || ctl_wr_enable) en_cycles++;
    end
    #1;
    chk("init_no_en", 32'(en_cycles), 32'd0);
    wait_acks("to_wr1", 0, 1);
    wr_req = 1'b0;
    settle(12);
    chk("wr_ack_once", 32'(wr_acks), 32'd1);
    chk("wr_commit_data", 32'(m_wdata), 32'h1234);
    chk("wr_commit_addr", 32'(m_waddr), 32'h000100);
    chk("wr_count", 32'(n_writes), 32'd1);
    init_len = 0;

    // Both clients held for four transactions
    br = rd_acks; bw = wr_acks;
    rd_addr = 22'h000200; wr_addr = 22'h000300; wr_data = 16'hBEEF;
`ifdef ARB_ROUND_ROBIN_EN
    exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
    exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
    rd_req = 1'b1; wr_req = 1'b1;
    wait_acks("to_both", br + 2, bw + 2);
`else
    for (int i = 0; i < 4; i++) exp_grant.push_back(2'b01);
    rd_req = 1'b1; wr_req = 1'b1;
    wait_acks("to_both", br + 4, bw);
`endif
    rd_req = 1'b0; wr_req = 1'b0;
    settle(15);
`ifdef ARB_ROUND_ROBIN_EN
    chk("both_rd_cnt", 32'(rd_acks - br), 32'd2);
    chk("both_wr_cnt", 32'(wr_acks - bw), 32'd2);
`else
    chk("both_rd_cnt", 32'(rd_acks - br), 32'd4);
    chk("both_wr_cnt", 32'(wr_acks - bw), 32'd0);
`endif
    chk("both_grants_done", 32'(exp_grant.size()), 32'd0);

    // Plain read
    br = rd_acks; bn = n_reads;
    rd_addr = 22'h000100;
    exp_grant.push_back(2'b01);
    rd_req = 1'b1;
    wait_acks("to_rd", br + 1, 0);
    rd_req = 1'b0;
    settle(10);
    chk("rd_one_exec", 32'(n_reads - bn), 32'd1);

    // Read issued exactly as the controller enters refresh
    br = rd_acks; bn = n_reads;
    rd_addr = 22'h0002A5;
    exp_grant.push_back(2'b01);
    ref_go = 1'b1; rd_req = 1'b1;
    @(posedge clk); #1 ref_go = 1'b0;
    wait_acks("to_ref", br + 1, 0);
    rd_req = 1'b0;
    settle(10);
    chk("ref_one_read", 32'(n_reads - bn), 32'd1);
    chk("ref_en_held", 32'(last_en_len >= 14), 32'd1);

    // Write requested while a read is in flight
    br = rd_acks; bw = wr_acks;
    rd_addr = 22'h000123; wr_addr = 22'h000456; wr_data = 16'hC0DE;
    exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
    rd_req = 1'b1;
    n = 0;
    while (!ctl_rd_enable && n < 50) begin @(negedge clk); #1; n++; end
    while (ctl_rd_enable && n < 100) begin @(negedge clk); #1; n++; end
    chk("rw_rd_in_busy", 32'(n < 100), 32'd1);
    wr_req = 1'b1;
    wait_acks("to_rw_rd", br + 1, 0);
    rd_req = 1'b0;
    wait_acks("to_rw_wr", 0, bw + 1);
    wr_req = 1'b0;
    settle(12);
    chk("w_after_rotate", 32'(rd_acks_at_wgrant), 32'(br + 1));
    chk("rw_wdata", 32'(m_wdata), 32'hC0DE);

    // Reset during drain counter 2, then a fresh read
    br = rd_acks;
    rd_addr = 22'h0003C3;
    exp_grant.push_back(2'b01);
    rd_req = 1'b1;
    n = 0;
    while (vld_run != 2 && n < 100) begin @(negedge clk); #1; n++; end
    chk("to_drain2", 32'(vld_run), 32'd2);
    rst = 1'b1; rd_req = 1'b0;
    sb.delete(); exp_grant.delete();
    @(negedge clk);
    check_reset_outs("midrst");
    #1 rst = 1'b0;
    settle(3);
    rd_addr = 22'h000ABC;
    exp_grant.push_back(2'b01);
    rd_req = 1'b1;
    wait_acks("to_post_rst", br + 1, 0);
    rd_req = 1'b0;
    settle(10);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
